// File: rtl/pe_status_cfg_if.sv
// Host config stream in, status-register write port out, for pe_status_cfg_writer.
interface pe_status_cfg_if #(
  parameter int NUM_PE = 64,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic              soft_clr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [NUM_PE-1:0] pe_sel;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output soft_clr, in_valid, in_data,
    input  in_ready, write_en, write_addr, write_data, pe_sel, busy, done, err
  );

  modport slave (
    input  soft_clr, in_valid, in_data,
    output in_ready, write_en, write_addr, write_data, pe_sel, busy, done, err
  );
endinterface

// File: rtl/pe_status_cfg_writer.sv
// Decodes host config packets (HDR0, HDR1, payload) into registered status-register
// writes to one PE or all PEs; malformed headers are reported and their payload drained.
module pe_status_cfg_writer #(
  parameter int NUM_PE   = 64,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int MAX_ADDR = 68
) (
  input  logic            clk,
  input  logic            rst,
  pe_status_cfg_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              bcast_q, bcast_d;
  logic [5:0]        pe_idx_q, pe_idx_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [5:0]        rem_q, rem_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NUM_PE-1:0] pe_sel_q, pe_sel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [5:0]        cnt;
  logic [ADDR_W+1:0] last_addr;
  logic              hdr_err;
  logic [NUM_PE-1:0] sel_mask;

  assign xfer = bus.in_valid & bus.in_ready;
  assign cnt  = bus.in_data[5:0];

  // Two extra bits keep start + 2*(count-1) from wrapping; count==0 is flagged separately.
  assign last_addr = (ADDR_W+2)'(start_addr_q) + (ADDR_W+2)'({cnt, 1'b0}) - (ADDR_W+2)'(2);

  assign hdr_err = (cnt == 6'd0) || start_addr_q[0] ||
                   (last_addr > (ADDR_W+2)'(MAX_ADDR)) ||
                   (!bcast_q && (32'(pe_idx_q) >= 32'(NUM_PE)));

  assign sel_mask = bcast_q ? {NUM_PE{1'b1}}
                            : ({{(NUM_PE-1){1'b0}}, 1'b1} << pe_idx_q);

  always_comb begin
    state_d      = state_q;
    bcast_d      = bcast_q;
    pe_idx_d     = pe_idx_q;
    start_addr_d = start_addr_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    pe_sel_d     = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: if (xfer) begin
        bcast_d      = bus.in_data[15];
        pe_idx_d     = bus.in_data[13:8];
        start_addr_d = bus.in_data[ADDR_W-1:0];
        state_d      = HDR1;
      end
      HDR1: if (xfer) begin
        rem_d = cnt;
        if (hdr_err) begin
          err_d   = 1'b1;
          state_d = (cnt == 6'd0) ? IDLE : DRAIN;
        end else begin
          cur_addr_d = start_addr_q;
          state_d    = DATA;
        end
      end
      DATA: if (xfer) begin
        write_en_d   = 1'b1;
        write_addr_d = cur_addr_q;
        write_data_d = bus.in_data;
        pe_sel_d     = sel_mask;
        cur_addr_d   = cur_addr_q + ADDR_W'(2);
        rem_d        = rem_q - 6'd1;
        // done is registered with the last write so both appear in the FIN cycle
        if (rem_q == 6'd1) begin
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      DRAIN: if (xfer) begin
        rem_d = rem_q - 6'd1;
        if (rem_q == 6'd1) state_d = IDLE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a word accepted this same cycle.
    if (bus.soft_clr) begin
      state_d      = IDLE;
      bcast_d      = 1'b0;
      pe_idx_d     = '0;
      start_addr_d = '0;
      cur_addr_d   = '0;
      rem_d        = '0;
      write_en_d   = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      pe_sel_d     = '0;
      done_d       = 1'b0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bcast_q      <= 1'b0;
      pe_idx_q     <= '0;
      start_addr_q <= '0;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      pe_sel_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcast_q      <= bcast_d;
      pe_idx_q     <= pe_idx_d;
      start_addr_q <= start_addr_d;
      cur_addr_q   <= cur_addr_d;
      rem_q        <= rem_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      pe_sel_q     <= pe_sel_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready   = (state_q != FIN);
  assign bus.busy       = (state_q != IDLE);
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.pe_sel     = pe_sel_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: doc/pe_status_cfg_writer.md
Name: pe_status_cfg_writer

Overview:
Host-side configuration sequencer that drives the write port of every PE's status register file.
- Accepts a stream of 16-bit configuration words over a valid/ready handshake.
- Decodes packet headers and emits timed write transactions (write_en/write_addr/write_data) with a per-PE select, addressed to one PE or broadcast to all.
- Sits between the accelerator IO interface and the PE array; active only during IO/boot configuration mode.

Parameters:
NUM_PE, 64, number of PEs driven; pe_sel width.
ADDR_W, 7, status register address width.
DATA_W, 16, config word / write_data width.
MAX_ADDR, 68, highest legal status register address (even only).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
soft_clr  input  1  synchronous abort; returns FSM to IDLE
in_valid  input  1  host config word valid
in_data  input  DATA_W  host config word
in_ready  output  1  block accepts word this cycle
write_en  output  1  status register write strobe (one cycle per word)
write_addr  output  ADDR_W  status register address
write_data  output  DATA_W  status register data
pe_sel  output  NUM_PE  per-PE write qualifier (PE i writes when write_en & pe_sel[i])
busy  output  1  packet in progress (state != IDLE)
done  output  1  one-cycle pulse: packet fully written without error
err  output  1  one-cycle pulse: packet header rejected

Behaviour:
- Reset is clk/rst: asynchronous, active-high.
  - All outputs reset to 0, except in_ready = 1.
  - FSM resets to IDLE; internal counters reset to 0.
- A word transfers on a cycle with in_valid & in_ready.
- in_ready = 1 in IDLE, HDR1, DATA and DRAIN; 0 in FIN.
- Packet format:
  - HDR0: [15] bcast, [13:8] pe_idx, [6:0] start_addr.
  - HDR1: [5:0] count (number of payload words).
  - Then count payload words.
- FSM states: IDLE, HDR1, DATA, DRAIN, FIN.
- IDLE: on transfer, latch bcast/pe_idx/start_addr, go to HDR1.
- HDR1: on transfer, latch count and check the header. It is an error if any of:
  - count == 0;
  - start_addr odd;
  - start_addr + 2*(count-1) > MAX_ADDR (computed in ≥8-bit arithmetic, no wrap);
  - !bcast && pe_idx >= NUM_PE.
- HDR1 transitions:
  - On error: pulse err next cycle. Go to DRAIN with remaining = count, or to IDLE if count == 0.
  - Otherwise: go to DATA with cur_addr = start_addr and remaining = count.
- DATA: on each transfer, the following cycle presents:
  - write_en = 1;
  - write_addr = cur_addr;
  - write_data = in_data;
  - pe_sel = all-ones if bcast, else one-hot(pe_idx).
- DATA bookkeeping: cur_addr += 2 and remaining -= 1 on each transfer. On the last word go to FIN.
- Write latency: exactly 1 cycle from acceptance to write_en. Back-to-back accepted words give back-to-back write_en cycles.
- In idle cycles (no transfer), write_en = 0 and pe_sel = 0. write_addr/write_data hold their last value.
- FIN: single cycle. done = 1 in that cycle, which coincides with the last word's write_en. Then go to IDLE.
- DRAIN: accept and discard words with no write_en. Decrement remaining; at 0 go to IDLE. done is not asserted.
- soft_clr has priority over all transitions:
  - next state IDLE, counters cleared;
  - write_en, done and err forced 0 the next cycle;
  - any word accepted in the same cycle is discarded.
- rst mid-packet: immediate abort. No partial write is issued after rst deasserts.
- in_valid low mid-packet stalls the packet indefinitely, with no timeout.

Test Plan:
- Unicast: HDR0 = 0x0500 (pe 5, addr 0), HDR1 = 1, data 0x0003 → one write_en cycle, addr 0, data 0x0003, pe_sel = 1<<5; done pulses with that write.
- Broadcast burst: HDR0 = 0x8002, HDR1 = 4, data A,B,C,D streamed back-to-back → four consecutive writes to addrs 2,4,6,8 with data A..D, pe_sel all-ones; done on the 4th write.
- Error/drain: HDR0 = 0x0043 (odd addr 67), HDR1 = 2, then 2 words → err one pulse, no write_en, in_ready stays 1, back in IDLE; next valid packet writes normally.
- Range check: start_addr 66, count 2 (last = 68) → accepted. Start_addr 66, count 3 → err, 3 words drained.
- Stalls: drop in_valid for 3 cycles between payload words → no write_en during gap, addresses still contiguous; busy held 1.
- Abort: assert soft_clr after the 2nd of 4 payload words → exactly 2 writes issued, no done, FSM IDLE. Async rst mid-packet → all outputs 0, in_ready 1.
